// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_write_arbiter_pkg                                        |
// | Purpose : Shared types and constants for the register-file write     |
// |           arbiter: address/data widths, arbiter FSM state encoding   |
// |           and the queued multi-cycle result entry.                   |
// | Ports   : none (package)                                             |
// | Config  : RF_ARB_BYPASS_EN is consumed by rf_write_arbiter only.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package rf_write_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int XLEN      = 32;

  // IDLE: queue empty. DRAIN: head waiting for a free write slot.
  // FORCE: one-cycle pipeline freeze so the head is guaranteed a slot.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] wr;
    logic [XLEN-1:0]      wd;
  } rf_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_result_fifo                                              |
// | Purpose : Small FIFO holding multi-cycle results waiting for the     |
// |           register-file write port. Exposes per-slot valid flags and |
// |           destination addresses so the owner can do a pending lookup.|
// | Ports   : clk, rst_n         clock / async active-low reset          |
// |           push, push_entry   write side (ignored when full w/o pop)  |
// |           pop                read side (ignored when empty)          |
// |           full, empty, count occupancy                               |
// |           head               oldest entry                            |
// |           entry_valid/_wr    flattened per-slot valid + destination  |
// | Params  : DEPTH  entries, power of two, >= 2                         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rf_result_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  rf_entry_t                      push_entry,
  input  logic                           pop,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH):0]         count,
  output rf_entry_t                      head,
  output logic [DEPTH-1:0]               entry_valid,
  output logic [DEPTH*RF_ADDR_W-1:0]     entry_wr
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  rf_entry_t            r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full  = (r_count == c_cnt_w'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A push while full is legal only if the head leaves on the same edge.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
    end
  end

  // Payload storage carries no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [c_ptr_w-1:0] w_off;
    assign w_off          = c_ptr_w'(i) - r_rd_ptr;
    assign entry_valid[i] = ({1'b0, w_off} < r_count);
    assign entry_wr[i*RF_ADDR_W +: RF_ADDR_W] = r_mem[i].wr;
  end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_write_arbiter                                            |
// | Purpose : Shares the single register-file write port between the     |
// |           in-order writeback stage and queued multi-cycle results.   |
// |           A starvation counter forces a one-cycle pipeline stall so  |
// |           the queue always drains; pending destinations are reported |
// |           to the hazard unit.                                        |
// | Ports   : clk, rst_n              clock / async active-low reset     |
// |           wb_we/wb_wr/wb_wd       writeback request                  |
// |           mc_valid/mc_wr/mc_wd    multi-cycle result, mc_ready back  |
// |           rD1, rD2 -> pend_hit1/2 pending lookup for decode          |
// |           stall_pipe              registered pipeline freeze         |
// |           rf_we/rf_wr/rf_wd       regfile write port                 |
// |           waw_err                 sticky wb-over-pending flag        |
// |           byp_hit1/2, byp_data1/2 (RF_ARB_BYPASS_EN only)            |
// | Params  : DEPTH (power of two, >=2), STARVE_LIMIT (1..15)            |
// | Config  : `define RF_ARB_BYPASS_EN adds same-cycle bypass outputs    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_we,
  input  logic [RF_ADDR_W-1:0] wb_wr,
  input  logic [XLEN-1:0]      wb_wd,
  input  logic                 mc_valid,
  input  logic [RF_ADDR_W-1:0] mc_wr,
  input  logic [XLEN-1:0]      mc_wd,
  output logic                 mc_ready,
  input  logic [RF_ADDR_W-1:0] rD1,
  input  logic [RF_ADDR_W-1:0] rD2,
  output logic                 pend_hit1,
  output logic                 pend_hit2,
  output logic                 stall_pipe,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_wr,
  output logic [XLEN-1:0]      rf_wd,
  output logic                 waw_err
`ifdef RF_ARB_BYPASS_EN
  ,
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [XLEN-1:0]      byp_data1,
  output logic [XLEN-1:0]      byp_data2
`endif
);

  localparam int         c_cnt_w        = $clog2(DEPTH) + 1;
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  arb_state_t                 r_state;
  arb_state_t                 w_state_next;
  logic [3:0]                 r_starve;
  logic [3:0]                 w_starve_next;
  logic [3:0]                 w_starve_inc;
  logic                       r_waw;

  logic                       w_push;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [c_cnt_w-1:0]         w_count;
  logic [c_cnt_w-1:0]         w_count_next;
  rf_entry_t                  w_push_entry;
  rf_entry_t                  w_head;
  logic [DEPTH-1:0]           w_ent_valid;
  logic [DEPTH*RF_ADDR_W-1:0] w_ent_wr;
  logic                       w_wb_grant;
  logic                       w_wb_match;
  logic                       w_denied;

  // Destination 0 is the hardwired zero register: accepted, never queued.
  assign mc_ready     = !w_full;
  assign w_push       = mc_valid && mc_ready && (mc_wr != '0);
  assign w_push_entry = {mc_wr, mc_wd};

  rf_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (w_push),
    .push_entry  (w_push_entry),
    .pop         (w_pop),
    .full        (w_full),
    .empty       (w_empty),
    .count       (w_count),
    .head        (w_head),
    .entry_valid (w_ent_valid),
    .entry_wr    (w_ent_wr)
  );

  // FORCE is held for exactly one cycle, so the stall is a state decode.
  assign stall_pipe = (r_state == FORCE);
  assign waw_err    = r_waw;

  // Write-port select. During a stall wb is dropped (the pipeline
  // re-presents it next cycle) and the queue head owns the port.
  always_comb begin
    rf_we      = 1'b0;
    rf_wr      = '0;
    rf_wd      = '0;
    w_pop      = 1'b0;
    w_wb_grant = 1'b0;
    if (stall_pipe) begin
      if (!w_empty) begin
        rf_we = 1'b1;
        rf_wr = w_head.wr;
        rf_wd = w_head.wd;
        w_pop = 1'b1;
      end
    end else if (wb_we && (wb_wr != '0)) begin
      rf_we      = 1'b1;
      rf_wr      = wb_wr;
      rf_wd      = wb_wd;
      w_wb_grant = 1'b1;
    end else if (!w_empty) begin
      rf_we = 1'b1;
      rf_wr = w_head.wr;
      rf_wd = w_head.wd;
      w_pop = 1'b1;
    end
  end

  // Pending lookup over live queue entries (including a head being
  // written this cycle: its value is not in the regfile until the edge).
  always_comb begin
    pend_hit1  = 1'b0;
    pend_hit2  = 1'b0;
    w_wb_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i]) begin
        if (w_ent_wr[i*RF_ADDR_W +: RF_ADDR_W] == rD1)   pend_hit1  = 1'b1;
        if (w_ent_wr[i*RF_ADDR_W +: RF_ADDR_W] == rD2)   pend_hit2  = 1'b1;
        if (w_ent_wr[i*RF_ADDR_W +: RF_ADDR_W] == wb_wr) w_wb_match = 1'b1;
      end
    end
    if (rD1 == '0) pend_hit1 = 1'b0;
    if (rD2 == '0) pend_hit2 = 1'b0;
  end

  // Next-state and starvation counter. The transition to FORCE happens on
  // the denied cycle that brings the count to the limit, so the stall
  // appears right after STARVE_LIMIT consecutive denials.
  always_comb begin
    w_state_next  = r_state;
    w_starve_next = '0;
    w_starve_inc  = r_starve + 4'd1;
    w_count_next  = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    w_denied      = (r_state == DRAIN) && !w_pop;
    case (r_state)
      IDLE: begin
        w_state_next = w_push ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (w_denied && (w_starve_inc >= c_starve_limit)) begin
          w_state_next = FORCE;
        end else if (w_denied) begin
          w_state_next  = DRAIN;
          w_starve_next = w_starve_inc;
        end else begin
          w_state_next = (w_count_next != '0) ? DRAIN : IDLE;
        end
      end
      FORCE: begin
        w_state_next = (w_count_next != '0) ? DRAIN : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_waw    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_starve <= w_starve_next;
      if (w_wb_grant && w_wb_match) r_waw <= 1'b1;
    end
  end

`ifdef RF_ARB_BYPASS_EN
  // Same-cycle read-after-write: forward the value being written now.
  assign byp_hit1  = rf_we && (rf_wr == rD1) && (rD1 != '0);
  assign byp_hit2  = rf_we && (rf_wr == rD2) && (rD2 != '0);
  assign byp_data1 = rf_wd;
  assign byp_data2 = rf_wd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rf_write_arbiter                                         |
// | Purpose : Self-checking bench for rf_write_arbiter (DEPTH=2,         |
// |           STARVE_LIMIT=4). Queued mc results are recorded in a       |
// |           scoreboard and matched against regfile writes.             |
// | Config  : RF_ARB_BYPASS_EN enables the bypass scenario.              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_rf_write_arbiter;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] wd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wd;
  logic        mc_valid;
  logic [4:0]  mc_wr;
  logic [31:0] mc_wd;
  logic        mc_ready;
  logic [4:0]  rD1;
  logic [4:0]  rD2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        waw_err;
`ifdef RF_ARB_BYPASS_EN
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
`endif

  int   n_tests;
  int   n_fail;
  bit   sb_on;
  exp_t mc_q[$];
  exp_t mon_e;
  logic mon_wb_slot;

  rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_we      (wb_we),
    .wb_wr      (wb_wr),
    .wb_wd      (wb_wd),
    .mc_valid   (mc_valid),
    .mc_wr      (mc_wr),
    .mc_wd      (mc_wd),
    .mc_ready   (mc_ready),
    .rD1        (rD1),
    .rD2        (rD2),
    .pend_hit1  (pend_hit1),
    .pend_hit2  (pend_hit2),
    .stall_pipe (stall_pipe),
    .rf_we      (rf_we),
    .rf_wr      (rf_wr),
    .rf_wd      (rf_wd),
    .waw_err    (waw_err)
`ifdef RF_ARB_BYPASS_EN
    ,
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2),
    .byp_data1  (byp_data1),
    .byp_data2  (byp_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor, sampling at the falling edge. A cycle where wb
  // should own the port must show the wb write; any other regfile write
  // must be the oldest recorded mc result.
  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      mon_wb_slot = wb_we && (wb_wr != 5'd0) && !stall_pipe;
      if (mon_wb_slot) begin
        n_tests++;
        if (rf_we !== 1'b1 || rf_wr !== wb_wr || rf_wd !== wb_wd) begin
          n_fail++;
          $display("FAIL sb_wb_write: got we=%0b wr=%0d wd=%0h expected we=1 wr=%0d wd=%0h",
                   rf_we, rf_wr, rf_wd, wb_wr, wb_wd);
        end
      end else if (rf_we === 1'b1) begin
        n_tests++;
        if (mc_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got write wr=%0d wd=%0h expected no write", rf_wr, rf_wd);
        end else begin
          mon_e = mc_q.pop_front();
          if (rf_wr !== mon_e.wr || rf_wd !== mon_e.wd) begin
            n_fail++;
            $display("FAIL sb_mc_write: got wr=%0d wd=%0h expected wr=%0d wd=%0h",
                     rf_wr, rf_wd, mon_e.wr, mon_e.wd);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_wr = '0; wb_wd = '0;
    mc_valid = 1'b0; mc_wr = '0; mc_wd = '0;
    rD1 = '0; rD2 = '0;
  endtask

  task automatic drained(input string name);
    repeat (3) tick();
    n_tests++;
    if (mc_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d pending expected 0", name, mc_q.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    sb_on = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({mc_ready, stall_pipe, rf_we, pend_hit1, pend_hit2, waw_err} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 100000",
               {mc_ready, stall_pipe, rf_we, pend_hit1, pend_hit2, waw_err});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    sb_on = 1'b1;
  endtask

  task automatic test_basic();
    tick();
    mc_valid = 1'b1; mc_wr = 5'd5; mc_wd = 32'h1234; rD1 = 5'd5;
    #1;
    n_tests++;
    if (mc_ready !== 1'b1 || rf_we !== 1'b0 || pend_hit1 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: got ready=%0b we=%0b pend=%0b expected 1 0 0", mc_ready, rf_we, pend_hit1);
    end
    mc_q.push_back('{wr: 5'd5, wd: 32'h1234});
    tick();
    mc_valid = 1'b0;
    #1;
    n_tests++;
    if (rf_we !== 1'b1 || rf_wr !== 5'd5 || rf_wd !== 32'h1234 || pend_hit1 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_write: got we=%0b wr=%0d wd=%0h pend=%0b expected 1 5 1234 1",
               rf_we, rf_wr, rf_wd, pend_hit1);
    end
    tick();
    #1;
    n_tests++;
    if (rf_we !== 1'b0 || pend_hit1 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: got we=%0b pend=%0b expected 0 0", rf_we, pend_hit1);
    end
    idle_inputs();
    drained("basic");
  endtask

  task automatic test_starve();
    tick();
    wb_we = 1'b1; wb_wr = 5'd10; wb_wd = 32'hB000_0000;
    mc_valid = 1'b1; mc_wr = 5'd7; mc_wd = 32'h77; rD1 = 5'd7;
    mc_q.push_back('{wr: 5'd7, wd: 32'h77});
    for (int i = 1; i <= 4; i++) begin
      tick();
      mc_valid = 1'b0;
      wb_wr = 5'(10 + i); wb_wd = 32'hB000_0000 + i;
      #1;
      n_tests++;
      if (stall_pipe !== 1'b0 || pend_hit1 !== 1'b1) begin
        n_fail++;
        $display("FAIL starve_denied_%0d: got stall=%0b pend=%0b expected 0 1", i, stall_pipe, pend_hit1);
      end
    end
    // Stall cycle: wb presents reg 20 but is dropped, head (7) is written.
    tick();
    wb_wr = 5'd20; wb_wd = 32'hB000_0020;
    #1;
    n_tests++;
    if (stall_pipe !== 1'b1 || rf_we !== 1'b1 || rf_wr !== 5'd7 || rf_wd !== 32'h77) begin
      n_fail++;
      $display("FAIL starve_force: got stall=%0b we=%0b wr=%0d wd=%0h expected 1 1 7 77",
               stall_pipe, rf_we, rf_wr, rf_wd);
    end
    // Re-presented wb is written the next cycle.
    tick();
    #1;
    n_tests++;
    if (stall_pipe !== 1'b0 || rf_we !== 1'b1 || rf_wr !== 5'd20 || rf_wd !== 32'hB000_0020) begin
      n_fail++;
      $display("FAIL starve_replay: got stall=%0b we=%0b wr=%0d wd=%0h expected 0 1 20 b0000020",
               stall_pipe, rf_we, rf_wr, rf_wd);
    end
    tick();
    #1;
    n_tests++;
    if (stall_pipe !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_one_cycle: got stall=%0b expected 0", stall_pipe);
    end
    idle_inputs();
    drained("starve");
  endtask

  task automatic test_full();
    tick();
    wb_we = 1'b1; wb_wr = 5'd1; wb_wd = 32'hB100_0000;
    mc_valid = 1'b1; mc_wr = 5'd11; mc_wd = 32'hC1;
    mc_q.push_back('{wr: 5'd11, wd: 32'hC1});
    tick();
    mc_wr = 5'd12; mc_wd = 32'hC2;
    #1;
    n_tests++;
    if (mc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready_one: got %0b expected 1", mc_ready);
    end
    mc_q.push_back('{wr: 5'd12, wd: 32'hC2});
    // Queue full: this offer must be refused and never appear later.
    tick();
    mc_wr = 5'd14; mc_wd = 32'hEE; rD1 = 5'd11; rD2 = 5'd12;
    #1;
    n_tests++;
    if (mc_ready !== 1'b0 || pend_hit1 !== 1'b1 || pend_hit2 !== 1'b1) begin
      n_fail++;
      $display("FAIL full_flags: got ready=%0b p1=%0b p2=%0b expected 0 1 1", mc_ready, pend_hit1, pend_hit2);
    end
    tick();
    mc_valid = 1'b0; wb_we = 1'b0;
    #1;
    n_tests++;
    if (rf_we !== 1'b1 || rf_wr !== 5'd11) begin
      n_fail++;
      $display("FAIL full_head_first: got we=%0b wr=%0d expected 1 11", rf_we, rf_wr);
    end
    // Push and pop on the same edge: occupancy must stay at one.
    tick();
    mc_valid = 1'b1; mc_wr = 5'd13; mc_wd = 32'hC3; rD1 = 5'd14; rD2 = 5'd13;
    mc_q.push_back('{wr: 5'd13, wd: 32'hC3});
    #1;
    n_tests++;
    if (mc_ready !== 1'b1 || rf_wr !== 5'd12 || pend_hit1 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: got ready=%0b wr=%0d p14=%0b expected 1 12 0", mc_ready, rf_wr, pend_hit1);
    end
    tick();
    mc_valid = 1'b0;
    #1;
    n_tests++;
    if (rf_we !== 1'b1 || rf_wr !== 5'd13 || pend_hit2 !== 1'b1) begin
      n_fail++;
      $display("FAIL full_last: got we=%0b wr=%0d p13=%0b expected 1 13 1", rf_we, rf_wr, pend_hit2);
    end
    tick();
    #1;
    n_tests++;
    if (rf_we !== 1'b0 || pend_hit2 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty: got we=%0b p13=%0b expected 0 0", rf_we, pend_hit2);
    end
    idle_inputs();
    drained("full");
  endtask

  task automatic test_zero_reg();
    tick();
    mc_valid = 1'b1; mc_wr = 5'd0; mc_wd = 32'hDEAD;
    #1;
    n_tests++;
    if (rf_we !== 1'b0 || mc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_mc: got we=%0b ready=%0b expected 0 1", rf_we, mc_ready);
    end
    tick();
    mc_valid = 1'b0; wb_we = 1'b1; wb_wr = 5'd0; wb_wd = 32'hBEEF;
    #1;
    n_tests++;
    if (rf_we !== 1'b0 || pend_hit1 !== 1'b0 || pend_hit2 !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_wb: got we=%0b p1=%0b p2=%0b expected 0 0 0", rf_we, pend_hit1, pend_hit2);
    end
    idle_inputs();
    drained("zero");
  endtask

  task automatic test_waw();
    tick();
    wb_we = 1'b1; wb_wr = 5'd2; wb_wd = 32'hB200_0000;
    mc_valid = 1'b1; mc_wr = 5'd9; mc_wd = 32'hC9; rD1 = 5'd9;
    mc_q.push_back('{wr: 5'd9, wd: 32'hC9});
    tick();
    mc_valid = 1'b0; wb_wr = 5'd9; wb_wd = 32'hB900_0000;
    #1;
    n_tests++;
    if (waw_err !== 1'b0 || pend_hit1 !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_before: got waw=%0b pend=%0b expected 0 1", waw_err, pend_hit1);
    end
    tick();
    wb_we = 1'b0;
    #1;
    n_tests++;
    if (waw_err !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_set: got %0b expected 1", waw_err);
    end
    repeat (3) tick();
    n_tests++;
    if (waw_err !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_sticky: got %0b expected 1", waw_err);
    end
    drained("waw");
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (waw_err !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_reset: got %0b expected 0", waw_err);
    end
    @(negedge clk) rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    tick();
    wb_we = 1'b1; wb_wr = 5'd3; wb_wd = 32'hB300_0000;
    mc_valid = 1'b1; mc_wr = 5'd6; mc_wd = 32'hC6; rD1 = 5'd6;
    mc_q.push_back('{wr: 5'd6, wd: 32'hC6});
    repeat (4) begin
      tick();
      mc_valid = 1'b0;
    end
    tick();
    #1;
    n_tests++;
    if (stall_pipe !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_stall: got %0b expected 1", stall_pipe);
    end
    // Asynchronous reset in the middle of the stall cycle.
    rst_n = 1'b0;
    wb_we = 1'b0;
    #1;
    mc_q.delete();
    n_tests++;
    if ({stall_pipe, rf_we, pend_hit1, mc_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_reset: got %b expected 0001", {stall_pipe, rf_we, pend_hit1, mc_ready});
    end
    @(negedge clk) rst_n = 1'b1;
    idle_inputs();
    drained("mid");
  endtask

`ifdef RF_ARB_BYPASS_EN
  task automatic test_bypass();
    tick();
    wb_we = 1'b1; wb_wr = 5'd3; wb_wd = 32'hA5; rD1 = 5'd4; rD2 = 5'd3;
    #1;
    n_tests++;
    if (byp_hit2 !== 1'b1 || byp_data2 !== 32'hA5 || byp_hit1 !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass: got h2=%0b d2=%0h h1=%0b expected 1 a5 0", byp_hit2, byp_data2, byp_hit1);
    end
    idle_inputs();
    drained("bypass");
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_starve();
    test_full();
    test_zero_reg();
    test_waw();
    test_reset_mid();
`ifdef RF_ARB_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
